vram_arbiter: RTL and testbench

Owns the single video RAM port and shares it between two requesters: the host write queue, which carries GPMC-originated writes already crossed into the vram_clk domain, and the scanout line fetcher, which issues burst reads. Scanout fetches have strict priority because they carry a display deadline; host writes use the idle cycles. All logic runs in the vram_clk domain and drives a synchronous single-port RAM with 1-cycle read latency.

---
 rtl/vram_arbiter.sv | 145 ++++++++++++++
 tb/tb_vram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: scanout burst reads have strict priority, host writes fill idle cycles.
// Optional VRAM_ARB_WRITE_SLOT_EN: lets a queued write in after every WRITE_SLOT_PERIOD burst reads.
module vram_arbiter #(
  parameter int ADDR_W            = 16,
  parameter int DATA_W            = 16,
  parameter int BURST_MAX         = 64,
  parameter int LEN_W             = 7,
  parameter int WRITE_SLOT_PERIOD = 8
) (
  input  logic              vram_clk,
  input  logic              reset,
  input  logic              wq_empty,
  input  logic [ADDR_W-1:0] wq_addr,
  input  logic [DATA_W-1:0] wq_data,
  output logic              wq_pop,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic [LEN_W-1:0]  fetch_len,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic              r_re_last, r_fv, r_done;
  logic              w_grant_rd, w_grant_zero, w_grant_wr, w_issue, w_slot;
  logic [LEN_W-1:0]  w_len;

  // Oversized requests are clamped to the longest burst the fetcher may ask for.
  assign w_len = (fetch_len > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : fetch_len;

`ifdef VRAM_ARB_WRITE_SLOT_EN
  localparam int CNT_W = $clog2(WRITE_SLOT_PERIOD + 1);
  logic [CNT_W-1:0] r_slot_cnt;

  assign w_slot = (r_state == S_READ) && (r_slot_cnt == CNT_W'(WRITE_SLOT_PERIOD)) && !wq_empty;

  // Counts read issues in the current burst; an empty queue at the slot point just restarts the count.
  always_ff @(posedge vram_clk) begin
    if (reset)            r_slot_cnt <= '0;
    else if (w_grant_rd)  r_slot_cnt <= CNT_W'(1);
    else if (w_slot)      r_slot_cnt <= '0;
    else if (w_issue)     r_slot_cnt <= (r_slot_cnt == CNT_W'(WRITE_SLOT_PERIOD)) ? CNT_W'(1)
                                                                                  : r_slot_cnt + CNT_W'(1);
  end
`else
  logic w_unused;
  assign w_slot   = 1'b0;
  assign w_unused = ^WRITE_SLOT_PERIOD;
`endif

  always_ff @(posedge vram_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_grant_rd) w_next = S_READ;
      S_READ: if (r_len == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // First burst word is issued in the grant cycle so the port is busy exactly in cycles 1..N.
  always_comb begin
    w_grant_rd   = 1'b0;
    w_grant_zero = 1'b0;
    w_grant_wr   = 1'b0;
    w_issue      = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (fetch_req) begin
            if (w_len != '0) w_grant_rd   = 1'b1;
            else             w_grant_zero = 1'b1;
          end else if (!wq_empty) begin
            w_grant_wr = 1'b1;
          end
        end
        S_READ: begin
          if (w_slot)            w_grant_wr = 1'b1;
          else if (r_len != '0)  w_issue    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fetch_ack = w_grant_rd | w_grant_zero;
  assign wq_pop    = w_grant_wr;

  always_ff @(posedge vram_clk) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_re_last <= 1'b0;
      r_fv      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      ram_we    <= w_grant_wr;
      ram_re    <= w_grant_rd | w_issue;
      r_re_last <= (w_grant_rd && w_len == LEN_W'(1)) || (w_issue && r_len == LEN_W'(1));
      if (w_grant_wr) begin
        ram_addr  <= wq_addr;
        ram_wdata <= wq_data;
      end else if (w_grant_rd) begin
        ram_addr  <= fetch_addr;
      end else if (w_issue) begin
        ram_addr  <= r_addr;
      end
      if (w_grant_rd) begin
        r_addr <= fetch_addr + ADDR_W'(1);
        r_len  <= w_len - LEN_W'(1);
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_len  <= r_len - LEN_W'(1);
      end
      r_fv   <= ram_re;
      r_done <= (ram_re && r_re_last) || w_grant_zero;
    end
  end

  assign fetch_valid = r_fv;
  assign fetch_done  = r_done;
  assign fetch_data  = r_fv ? ram_rdata : '0;
  assign busy        = (r_state == S_READ);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes expected RAM/fetch events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset, wq_empty, wq_pop, fetch_req, fetch_ack;
  logic [15:0] wq_addr, wq_data, fetch_addr, fetch_data, ram_addr, ram_wdata, ram_rdata;
  logic [6:0]  fetch_len;
  logic        fetch_valid, fetch_done, ram_we, ram_re, busy;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .vram_clk(clk), .reset(reset),
    .wq_empty(wq_empty), .wq_addr(wq_addr), .wq_data(wq_data), .wq_pop(wq_pop),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_len(fetch_len), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid), .fetch_done(fetch_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic v; logic [15:0] d; logic dn; } fv_t;

  wr_t         wf[$];
  wr_t         q_wr[$];
  logic [15:0] q_rd[$];
  fv_t         q_fv[$];
  int          tests = 0;
  int          fails = 0;
  bit          pop_pend = 1'b0;

  function automatic logic [15:0] rd_model(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  always @(posedge clk) if (ram_re) ram_rdata <= rd_model(ram_addr);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event, value 0x%0h, nothing expected", nm, act);
  endtask

  always @(negedge clk) begin
    wr_t w;
    fv_t f;
    logic [15:0] a;
    pop_pend = wq_pop;
    if (ram_we) begin
      check("we_excl_re", 32'(ram_re), 32'd0);
      if (q_wr.size() == 0) unexpected("ram_write", 32'(ram_addr));
      else begin
        w = q_wr.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(w.a));
        check("wr_data", 32'(ram_wdata), 32'(w.d));
      end
    end
    if (ram_re) begin
      if (q_rd.size() == 0) unexpected("ram_read", 32'(ram_addr));
      else begin
        a = q_rd.pop_front();
        check("rd_addr", 32'(ram_addr), 32'(a));
      end
    end
    if (fetch_valid || fetch_done) begin
      if (q_fv.size() == 0) unexpected("fetch_out", 32'({fetch_valid, fetch_done}));
      else begin
        f = q_fv.pop_front();
        check("fv_valid", 32'(fetch_valid), 32'(f.v));
        check("fv_done", 32'(fetch_done), 32'(f.dn));
        if (f.v) check("fv_data", 32'(fetch_data), 32'(f.d));
      end
    end
  end

  task automatic refresh();
    wq_empty = (wf.size() == 0);
    if (wf.size() > 0) begin
      wq_addr = wf[0].a;
      wq_data = wf[0].d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_pend && wf.size() > 0) wf.delete(0);
    pop_pend = 1'b0;
    refresh();
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wf.push_back(w);
    q_wr.push_back(w);
    refresh();
  endtask

  task automatic push_fetch_exp(input logic [15:0] addr, input int len);
    fv_t f;
    logic [15:0] a;
    for (int i = 0; i < len; i++) begin
      a = addr + 16'(i);
      q_rd.push_back(a);
      f.v = 1'b1;
      f.d = rd_model(a);
      f.dn = (i == len - 1);
      q_fv.push_back(f);
    end
  endtask

  // Called at posedge+1; leaves off at posedge+1 of cycle N+2.
  task automatic do_fetch(input logic [15:0] addr, input int n, input bit pop_end);
    fetch_req = 1'b1;
    fetch_addr = addr;
    fetch_len = 7'(n);
    push_fetch_exp(addr, n);
    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      check($sformatf("burst_ack c%0d", c), 32'(fetch_ack), 32'(c == 0));
      check($sformatf("burst_busy c%0d", c), 32'(busy), 32'(c >= 1 && c <= n));
      check($sformatf("burst_re c%0d", c), 32'(ram_re), 32'(c >= 1 && c <= n));
      check($sformatf("burst_valid c%0d", c), 32'(fetch_valid), 32'(c >= 2 && c <= n + 1));
      check($sformatf("burst_done c%0d", c), 32'(fetch_done), 32'(c == n + 1));
      check($sformatf("burst_pop c%0d", c), 32'(wq_pop), 32'(pop_end && c == n + 1));
      tick();
      if (c == 0) fetch_req = 1'b0;
    end
  endtask

  initial begin
    fv_t f;
    reset = 1'b1;
    fetch_req = 1'b0;
    fetch_addr = '0;
    fetch_len = '0;
    wq_addr = '0;
    wq_data = '0;
    wq_empty = 1'b1;

    // Requests presented during reset must be ignored.
    push_wr(16'h0010, 16'hAAAA);
    push_wr(16'h0011, 16'hBBBB);
    push_wr(16'h0012, 16'hCCCC);
    fetch_req = 1'b1;
    fetch_addr = 16'h0ABC;
    fetch_len = 7'd4;
    tick();
    tick();
    @(negedge clk);
    check("rst_ack", 32'(fetch_ack), 32'd0);
    check("rst_pop", 32'(wq_pop), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_re", 32'(ram_re), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_done", 32'(fetch_done), 32'd0);
    check("rst_data", 32'(fetch_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    fetch_req = 1'b0;

    // Three back-to-back writes.
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("wr3_pop c%0d", c), 32'(wq_pop), 32'(c < 3));
      check($sformatf("wr3_we c%0d", c), 32'(ram_we), 32'(c >= 1 && c <= 3));
      check($sformatf("wr3_re c%0d", c), 32'(ram_re), 32'd0);
      tick();
    end

    do_fetch(16'h0100, 4, 1'b0);

    // Fetch beats a pending write; the write goes right after the burst.
    push_wr(16'h0020, 16'hDDDD);
    do_fetch(16'h0140, 4, 1'b1);
    tick();

    do_fetch(16'hFFFE, 4, 1'b0);

    // Zero-length fetch.
    fetch_req = 1'b1;
    fetch_addr = 16'h0777;
    fetch_len = 7'd0;
    f.v = 1'b0;
    f.d = '0;
    f.dn = 1'b1;
    q_fv.push_back(f);
    @(negedge clk);
    check("zl_ack", 32'(fetch_ack), 32'd1);
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    check("zl_done", 32'(fetch_done), 32'd1);
    check("zl_valid", 32'(fetch_valid), 32'd0);
    check("zl_re", 32'(ram_re), 32'd0);
    check("zl_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    check("zl_done_clr", 32'(fetch_done), 32'd0);
    check("zl_re2", 32'(ram_re), 32'd0);
    tick();

    // Reset during the second read cycle of an 8-word burst.
    fetch_req = 1'b1;
    fetch_addr = 16'h0200;
    fetch_len = 7'd8;
    q_rd.push_back(16'h0200);
    q_rd.push_back(16'h0201);
    f.v = 1'b1;
    f.d = rd_model(16'h0200);
    f.dn = 1'b0;
    q_fv.push_back(f);
    @(negedge clk);
    check("mr_ack", 32'(fetch_ack), 32'd1);
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    check("mr_re1", 32'(ram_re), 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mr_re2", 32'(ram_re), 32'd1);
    check("mr_busy2", 32'(busy), 32'd1);
    tick();
    reset = 1'b0;
    push_wr(16'h0300, 16'h1234);
    @(negedge clk);
    check("mr_re_clr", 32'(ram_re), 32'd0);
    check("mr_we_clr", 32'(ram_we), 32'd0);
    check("mr_addr_clr", 32'(ram_addr), 32'd0);
    check("mr_valid_clr", 32'(fetch_valid), 32'd0);
    check("mr_done_clr", 32'(fetch_done), 32'd0);
    check("mr_data_clr", 32'(fetch_data), 32'd0);
    check("mr_busy_clr", 32'(busy), 32'd0);
    check("mr_pop", 32'(wq_pop), 32'd1);
    tick();
    @(negedge clk);
    check("mr_we", 32'(ram_we), 32'd1);
    tick();
    @(negedge clk);
    check("mr_no_done", 32'(fetch_done), 32'd0);
    tick();

`ifdef VRAM_ARB_WRITE_SLOT_EN
    // 16-word burst with two queued writes: one slot after read 8, one after read 16.
    push_wr(16'h0400, 16'h1111);
    push_wr(16'h0401, 16'h2222);
    fetch_req = 1'b1;
    fetch_addr = 16'h0500;
    fetch_len = 7'd16;
    push_fetch_exp(16'h0500, 16);
    for (int c = 0; c <= 19; c++) begin
      @(negedge clk);
      check($sformatf("ws_pop c%0d", c), 32'(wq_pop), 32'(c == 8 || c == 17));
      check($sformatf("ws_re c%0d", c), 32'(ram_re), 32'((c >= 1 && c <= 8) || (c >= 10 && c <= 17)));
      check($sformatf("ws_we c%0d", c), 32'(ram_we), 32'(c == 9 || c == 18));
      check($sformatf("ws_valid c%0d", c), 32'(fetch_valid), 32'((c >= 2 && c <= 9) || (c >= 11 && c <= 18)));
      check($sformatf("ws_done c%0d", c), 32'(fetch_done), 32'(c == 18));
      check($sformatf("ws_busy c%0d", c), 32'(busy), 32'(c >= 1 && c <= 17));
      tick();
      if (c == 0) fetch_req = 1'b0;
    end
`endif

    tick();
    tick();
    check("sb_wr_left", 32'(q_wr.size()), 32'd0);
    check("sb_rd_left", 32'(q_rd.size()), 32'd0);
    check("sb_fv_left", 32'(q_fv.size()), 32'd0);
    check("wq_left", 32'(wf.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
